vmr_tree_scheduler: RTL and testbench

Job-level round-robin arbiter that shares one `vector_multiply_reduction_tree` instance between NUM_REQ requesters. Each requester streams a job of one or more N-lane vector beats, with the final beat marked `last`. The scheduler locks the tree to one requester for the whole job and remembers job ownership in a tag FIFO. It returns every tree result to the owning requester. It sits between the requester front-ends and the tree; the tree has no backpressure, so result sinks must always accept.

---
 rtl/vmr_sched_pkg.sv | 33 +++
 rtl/vmr_tag_fifo.sv | 51 +++++
 rtl/vmr_tree_scheduler.sv | 163 ++++++++++++++++
 tb/tb_vmr_tree_scheduler.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vmr_sched_pkg.sv
// Shared types and helpers for the multiply-reduction tree scheduler.
package vmr_sched_pkg;

  typedef enum logic {StIdle, StLocked} sched_state_e;

  // Helpers work on a fixed-width vector; callers slice down to NumReq bits.
  localparam int unsigned MaxReq = 32;
  localparam int unsigned MaxIdW = $clog2(MaxReq);

  function automatic logic [MaxReq-1:0] id_onehot(input int unsigned id);
    return {{(MaxReq-1){1'b0}}, 1'b1} << id;
  endfunction

  // First set bit at or after ptr, wrapping modulo num.
  function automatic int unsigned rr_pick(input logic [MaxReq-1:0] valid,
                                          input int unsigned ptr,
                                          input int unsigned num);
    int unsigned pick;
    int unsigned idx;
    logic found;
    pick = ptr;
    found = 1'b0;
    for (int unsigned i = 0; i < MaxReq; i++) begin
      idx = (ptr + i) % num;
      if (i < num && !found && valid[idx[MaxIdW-1:0]]) begin
        pick = idx;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/vmr_tag_fifo.sv
// Ownership tag FIFO: one requester id per job currently inside the tree.
module vmr_tag_fifo #(
  parameter int unsigned Width = 2,
  parameter int unsigned Depth = 8
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       push_i,
  input  logic [Width-1:0]           data_i,
  input  logic                       pop_i,
  output logic [Width-1:0]           head_o,
  output logic [$clog2(Depth):0]     count_o,
  output logic                       full_o,
  output logic                       empty_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = PtrW + 1;

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q;
  logic             push_ok, pop_ok;

  assign full_o  = (count_q == CntW'(Depth));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];
  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;

  always_ff @(posedge clk_i) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  // Depth is a power of two, so pointers wrap naturally.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      count_q <= count_q + CntW'(push_ok) - CntW'(pop_ok);
    end
  end

endmodule

// File: rtl/vmr_tree_scheduler.sv
// Job-level round-robin arbiter sharing one multiply-reduction tree between requesters.
// Define VMR_SCHED_STATS_EN to add the stat_jobs_o / stat_busy_cycles_o counters.
module vmr_tree_scheduler
  import vmr_sched_pkg::*;
#(
  parameter int unsigned BitWidth = 16,
  parameter int unsigned N        = 8,
  parameter int unsigned NumReq   = 4,
  parameter int unsigned TagDepth = 8
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [NumReq-1:0]            req_valid_i,
  input  logic [NumReq-1:0]            req_last_i,
  input  logic [NumReq*N*BitWidth-1:0] req_in0_i,
  input  logic [NumReq*N*BitWidth-1:0] req_in1_i,
  output logic [NumReq-1:0]            req_ready_o,
  output logic [N*BitWidth-1:0]        tree_in0_o,
  output logic [N*BitWidth-1:0]        tree_in1_o,
  output logic                         tree_in_valid_o,
  output logic                         tree_in_last_o,
  input  logic [BitWidth-1:0]          tree_out_i,
  input  logic                         tree_out_valid_i,
  input  logic                         tree_out_last_i,
  output logic [BitWidth-1:0]          res_data_o,
  output logic [NumReq-1:0]            res_valid_o,
  output logic                         res_last_o,
  output logic                         busy_o,
  output logic                         err_orphan_o
`ifdef VMR_SCHED_STATS_EN
  ,
  output logic [31:0]                  stat_jobs_o,
  output logic [31:0]                  stat_busy_cycles_o
`endif
);

  localparam int unsigned IdW  = $clog2(NumReq);
  localparam int unsigned CntW = $clog2(TagDepth) + 1;
  localparam int unsigned VecW = N * BitWidth;

  sched_state_e     state_q, state_d;
  logic [IdW-1:0]   grant_q, grant_d, rr_q, rr_d;
  logic [MaxReq-1:0] grant_oh, head_oh;
  logic             beat_acc, tag_push, tag_pop, tag_full, tag_empty;
  logic [IdW-1:0]   tag_head;
  logic [CntW-1:0]  tag_count;
  logic [VecW-1:0]  tree_in0_q, tree_in1_q;
  logic             tree_in_valid_q, tree_in_last_q;
  logic [BitWidth-1:0] res_data_q;
  logic [NumReq-1:0] res_valid_q;
  logic             res_last_q, err_orphan_q;

  assign grant_oh = id_onehot(32'(grant_q));
  assign head_oh  = id_onehot(32'(tag_head));
  // Only the job-ending result retires a tag; orphans never pop.
  assign tag_pop  = tree_out_valid_i & tree_out_last_i & ~tag_empty;

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    rr_d        = rr_q;
    tag_push    = 1'b0;
    beat_acc    = 1'b0;
    req_ready_o = '0;
    unique case (state_q)
      StIdle: begin
        if (|req_valid_i && !tag_full) begin
          grant_d  = IdW'(rr_pick(MaxReq'(req_valid_i), 32'(rr_q), NumReq));
          tag_push = 1'b1;
          state_d  = StLocked;
        end
      end
      StLocked: begin
        req_ready_o = grant_oh[NumReq-1:0];
        beat_acc    = req_valid_i[grant_q];
        if (beat_acc && req_last_i[grant_q]) begin
          state_d = StIdle;
          rr_d    = IdW'((32'(grant_q) + 32'd1) % NumReq);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q         <= StIdle;
      grant_q         <= '0;
      rr_q            <= '0;
      tree_in0_q      <= '0;
      tree_in1_q      <= '0;
      tree_in_valid_q <= 1'b0;
      tree_in_last_q  <= 1'b0;
      res_data_q      <= '0;
      res_valid_q     <= '0;
      res_last_q      <= 1'b0;
      err_orphan_q    <= 1'b0;
    end else begin
      state_q         <= state_d;
      grant_q         <= grant_d;
      rr_q            <= rr_d;
      tree_in_valid_q <= beat_acc;
      tree_in_last_q  <= beat_acc & req_last_i[grant_q];
      if (beat_acc) begin
        tree_in0_q <= req_in0_i[32'(grant_q)*VecW +: VecW];
        tree_in1_q <= req_in1_i[32'(grant_q)*VecW +: VecW];
      end
      res_valid_q <= '0;
      if (tree_out_valid_i) begin
        res_data_q <= tree_out_i;
        res_last_q <= tree_out_last_i;
        if (tag_empty) begin
          err_orphan_q <= 1'b1;
        end else begin
          res_valid_q <= head_oh[NumReq-1:0];
        end
      end
    end
  end

  vmr_tag_fifo #(
    .Width (IdW),
    .Depth (TagDepth)
  ) u_tag_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (tag_push),
    .data_i  (grant_d),
    .pop_i   (tag_pop),
    .head_o  (tag_head),
    .count_o (tag_count),
    .full_o  (tag_full),
    .empty_o (tag_empty)
  );

  assign tree_in0_o      = tree_in0_q;
  assign tree_in1_o      = tree_in1_q;
  assign tree_in_valid_o = tree_in_valid_q;
  assign tree_in_last_o  = tree_in_last_q;
  assign res_data_o      = res_data_q;
  assign res_valid_o     = res_valid_q;
  assign res_last_o      = res_last_q;
  assign err_orphan_o    = err_orphan_q;
  assign busy_o          = (state_q == StLocked) | (tag_count != '0);

`ifdef VMR_SCHED_STATS_EN
  logic [31:0] stat_jobs_q, stat_busy_cycles_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stat_jobs_q        <= '0;
      stat_busy_cycles_q <= '0;
    end else begin
      if (tag_pop) stat_jobs_q <= stat_jobs_q + 32'd1;
      if (busy_o)  stat_busy_cycles_q <= stat_busy_cycles_q + 32'd1;
    end
  end

  assign stat_jobs_o        = stat_jobs_q;
  assign stat_busy_cycles_o = stat_busy_cycles_q;
`endif

endmodule

// File: tb/tb_vmr_tree_scheduler.sv
// Randomized bench for vmr_tree_scheduler with a fixed-latency tree model and a queue-based
// reference model of arbitration, ownership and result routing.
module tb_vmr_tree_scheduler;

  localparam int unsigned BW   = 16;
  localparam int unsigned N    = 8;
  localparam int unsigned NR   = 4;
  localparam int unsigned TD   = 2;
  localparam int unsigned LAT  = 6;
  localparam int unsigned VW   = N * BW;
  localparam int          NCYC = 4000;

  logic clk = 1'b0;
  logic rst;
  logic [NR-1:0]    req_valid, req_last, req_ready;
  logic [NR*VW-1:0] req_in0, req_in1;
  logic [VW-1:0]    tree_in0, tree_in1;
  logic             tree_in_valid, tree_in_last;
  logic [BW-1:0]    tree_out;
  logic             tree_out_valid, tree_out_last;
  logic [BW-1:0]    res_data;
  logic [NR-1:0]    res_valid;
  logic             res_last, busy, err_orphan;
`ifdef VMR_SCHED_STATS_EN
  logic [31:0]      stat_jobs, stat_busy_cycles;
`endif

  always #5 clk = ~clk;

  vmr_tree_scheduler #(
    .BitWidth (BW),
    .N        (N),
    .NumReq   (NR),
    .TagDepth (TD)
  ) dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .req_valid_i      (req_valid),
    .req_last_i       (req_last),
    .req_in0_i        (req_in0),
    .req_in1_i        (req_in1),
    .req_ready_o      (req_ready),
    .tree_in0_o       (tree_in0),
    .tree_in1_o       (tree_in1),
    .tree_in_valid_o  (tree_in_valid),
    .tree_in_last_o   (tree_in_last),
    .tree_out_i       (tree_out),
    .tree_out_valid_i (tree_out_valid),
    .tree_out_last_i  (tree_out_last),
    .res_data_o       (res_data),
    .res_valid_o      (res_valid),
    .res_last_o       (res_last),
    .busy_o           (busy),
    .err_orphan_o     (err_orphan)
`ifdef VMR_SCHED_STATS_EN
    ,
    .stat_jobs_o        (stat_jobs),
    .stat_busy_cycles_o (stat_busy_cycles)
`endif
  );

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Requester front-ends.
  int          beats_left [NR];
  bit          pend       [NR];
  bit          acc_flag   [NR];
  logic [VW-1:0] d0 [NR];
  logic [VW-1:0] d1 [NR];

  // Reference model state.
  bit          m_locked;
  int          m_gid, m_rr;
  int          tags[$];
  logic        e_tiv, e_til, e_rl, e_orph;
  logic [VW-1:0] e_t0, e_t1;
  logic [BW-1:0] e_rd;
  logic [NR-1:0] e_rv;
  logic [31:0] e_jobs, e_bcyc;

  // Tree model: fixed-latency delay line of dot products.
  logic        pv [LAT];
  logic        pl [LAT];
  logic [BW-1:0] pd [LAT];

  function automatic logic [BW-1:0] dot(input logic [VW-1:0] a, input logic [VW-1:0] b);
    logic [BW-1:0] s;
    s = '0;
    for (int i = 0; i < N; i++) s = s + a[i*BW +: BW] * b[i*BW +: BW];
    return s;
  endfunction

  function automatic logic [VW-1:0] rand_vec();
    logic [VW-1:0] v;
    for (int i = 0; i < VW / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic reset_model();
    m_locked = 0; m_gid = 0; m_rr = 0;
    tags.delete();
    e_tiv = 0; e_til = 0; e_rl = 0; e_orph = 0;
    e_t0 = '0; e_t1 = '0; e_rd = '0; e_rv = '0;
    e_jobs = '0; e_bcyc = '0;
    for (int r = 0; r < NR; r++) acc_flag[r] = 0;
  endtask

  task automatic idle_requesters();
    for (int r = 0; r < NR; r++) begin
      pend[r] = 0; beats_left[r] = 0; d0[r] = '0; d1[r] = '0;
    end
  endtask

  task automatic new_beat(input int r);
    d0[r] = rand_vec();
    d1[r] = rand_vec();
    pend[r] = 1;
  endtask

  task automatic drive_reqs();
    for (int r = 0; r < NR; r++) begin
      req_valid[r] = pend[r];
      req_last[r]  = pend[r] && (beats_left[r] == 1);
      req_in0[r*VW +: VW] = d0[r];
      req_in1[r*VW +: VW] = d1[r];
    end
  endtask

  task automatic check_outputs();
    logic [NR-1:0] e_ready;
    e_ready = '0;
    if (m_locked) e_ready[m_gid] = 1'b1;
    check_eq("req_ready", req_ready, e_ready);
    check_eq("tree_in_valid", tree_in_valid, e_tiv);
    check_eq("tree_in_last", tree_in_last, e_til);
    check_eq("tree_in0", tree_in0, e_t0);
    check_eq("tree_in1", tree_in1, e_t1);
    check_eq("res_valid", res_valid, e_rv);
    check_eq("res_data", res_data, e_rd);
    check_eq("res_last", res_last, e_rl);
    check_eq("busy", busy, (m_locked || tags.size() != 0));
    check_eq("err_orphan", err_orphan, e_orph);
`ifdef VMR_SCHED_STATS_EN
    check_eq("stat_jobs", stat_jobs, e_jobs);
    check_eq("stat_busy_cycles", stat_busy_cycles, e_bcyc);
`endif
  endtask

  task automatic tree_step();
    for (int i = LAT - 1; i > 0; i--) begin
      pv[i] = pv[i-1]; pl[i] = pl[i-1]; pd[i] = pd[i-1];
    end
    pv[0] = tree_in_valid;
    pl[0] = tree_in_last;
    pd[0] = dot(tree_in0, tree_in1);
    tree_out_valid = pv[LAT-1];
    tree_out_last  = pv[LAT-1] & pl[LAT-1];
    tree_out       = pd[LAT-1];
  endtask

  // Predicts the register state after the coming clock edge from the driven inputs.
  task automatic model_step();
    bit acc, last_acc, grant, pop, busy_now, found;
    int acc_id, idx;
    acc      = m_locked && req_valid[m_gid];
    acc_id   = m_gid;
    last_acc = acc && req_last[m_gid];
    busy_now = m_locked || tags.size() != 0;
    pop      = tree_out_valid && tree_out_last && tags.size() != 0;
    grant    = !m_locked && (|req_valid) && tags.size() < TD;

    e_rv = '0;
    if (tree_out_valid) begin
      e_rd = tree_out;
      e_rl = tree_out_last;
      if (tags.size() == 0) e_orph = 1;
      else e_rv[tags[0]] = 1'b1;
    end
    e_tiv = acc;
    e_til = last_acc;
    if (acc) begin
      e_t0 = d0[m_gid];
      e_t1 = d1[m_gid];
    end

    if (pop) begin
      void'(tags.pop_front());
      e_jobs = e_jobs + 32'd1;
    end
    if (busy_now) e_bcyc = e_bcyc + 32'd1;

    if (last_acc) begin
      m_locked = 0;
      m_rr = (m_gid + 1) % NR;
    end else if (grant) begin
      found = 0;
      for (int k = 0; k < NR; k++) begin
        idx = (m_rr + k) % NR;
        if (!found && req_valid[idx]) begin
          m_gid = idx;
          found = 1;
        end
      end
      m_locked = 1;
      tags.push_back(m_gid);
    end

    for (int r = 0; r < NR; r++) acc_flag[r] = 0;
    if (acc) acc_flag[acc_id] = 1;
  endtask

  initial begin
    int rst_rel, quiet_until;
    bit did_mid_rst;
    rst = 1'b1;
    req_valid = '0; req_last = '0; req_in0 = '0; req_in1 = '0;
    tree_out = '0; tree_out_valid = 1'b0; tree_out_last = 1'b0;
    for (int i = 0; i < LAT; i++) begin
      pv[i] = 0; pl[i] = 0; pd[i] = '0;
    end
    reset_model();
    idle_requesters();
    rst_rel = 2;
    quiet_until = 0;
    did_mid_rst = 0;

    for (int cyc = 0; cyc < NCYC; cyc++) begin
      @(negedge clk);
      check_outputs();
      tree_step();
      for (int r = 0; r < NR; r++) begin
        if (acc_flag[r]) begin
          pend[r] = 0;
          beats_left[r]--;
        end
      end

      if (rst) begin
        if (cyc >= rst_rel) rst = 1'b0;
      end else if (!did_mid_rst && cyc >= 1500 && m_locked && e_tiv) begin
        // Short pulse so beats already in the tree come back as orphans.
        rst = 1'b1;
        did_mid_rst = 1;
        rst_rel = cyc + 2;
        quiet_until = cyc + LAT + 8;
        reset_model();
        idle_requesters();
      end

      if (!rst) begin
        if (did_mid_rst && cyc == quiet_until) check_eq("orphan_after_reset", err_orphan, 1'b1);
        for (int r = 0; r < NR; r++) begin
          if (!pend[r]) begin
            if (cyc < 80) begin
              beats_left[r] = 1;
              new_beat(r);
            end else if (cyc > quiet_until) begin
              if (beats_left[r] > 0) begin
                if ($urandom_range(0, 3) != 0) new_beat(r);
              end else if ($urandom_range(0, 3) == 0) begin
                beats_left[r] = $urandom_range(1, 4);
                new_beat(r);
              end
            end
          end
        end
        drive_reqs();
        model_step();
      end else begin
        drive_reqs();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
